// File: rtl/tlc5955_pkg.sv
// Constants shared by the TLC5955 receiver and controller: frame geometry
// and the key that marks a control-data latch.
package tlc5955_pkg;

  localparam int BitsPerDevice = 769;
  localparam int CtrlBitIndex  = 768;
  localparam logic [7:0] CtrlKey = 8'h96;

  // Width of a bit counter that can reach a full chained frame.
  function automatic int frame_cnt_width(input int daisy_chain);
    return $clog2(BitsPerDevice * daisy_chain + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous level with a registered
// rising-edge detector behind the last stage.
module sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], din};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign rise = sync_q[SyncStages-1] & ~prev_q;

endmodule

// File: rtl/tlc5955_receiver.sv
// Emulates the serial input side of a chain of TLC5955 LED drivers: shifts
// mosi on sclk, mirrors the chain's SOUT on miso and captures frames on lat.
module tlc5955_receiver
  import tlc5955_pkg::*;
#(
  parameter int DaisyChain = 1,
  parameter int SyncStages = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sclk,
  input  logic                                mosi,
  input  logic                                lat,
  output logic                                miso,
  output logic                                out_valid,
  output logic [BitsPerDevice*DaisyChain-1:0] out_data,
  output logic [DaisyChain-1:0]               out_ctrl,
  output logic                                frame_err
);

  localparam int FrameBits = BitsPerDevice * DaisyChain;
  localparam int CntW      = frame_cnt_width(DaisyChain);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FrameBits);

  // out_valid is a one-cycle strobe with no back-pressure: out_data, out_ctrl
  // and frame_err are valid in that cycle, and data/ctrl hold until the next.
  logic                  sclk_rise;
  logic                  lat_rise;
  logic [SyncStages-1:0] mosi_sync;
  logic [FrameBits-1:0]  sr_q;
  logic [FrameBits-1:0]  sr_next;
  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       cnt_next;
  logic [DaisyChain-1:0] ctrl_next;

  sync_edge #(.SyncStages(SyncStages)) u_sclk_edge (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .rise  (sclk_rise)
  );

  sync_edge #(.SyncStages(SyncStages)) u_lat_edge (
    .clk   (clk),
    .reset (reset),
    .din   (lat),
    .rise  (lat_rise)
  );

  // A shift coincident with a latch is applied first, so the latched frame
  // and the length check both see the new bit.
  always_comb begin
    sr_next  = sr_q;
    cnt_next = cnt_q;
    if (sclk_rise) begin
      sr_next = {sr_q[FrameBits-2:0], mosi_sync[SyncStages-1]};
      if (cnt_q != '1) begin
        cnt_next = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    ctrl_next = '0;
    for (int d = 0; d < DaisyChain; d++) begin
      ctrl_next[d] = sr_next[d*BitsPerDevice + CtrlBitIndex];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_sync <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      miso      <= 1'b0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SyncStages-2:0], mosi};
      sr_q      <= sr_next;
      miso      <= sr_q[FrameBits-1];
      out_valid <= lat_rise;
      frame_err <= lat_rise && (cnt_next != FrameCnt);
      if (lat_rise) begin
        out_data <= sr_next;
        out_ctrl <= ctrl_next;
        cnt_q    <= '0;
      end else begin
        cnt_q    <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_tlc5955_receiver.sv
// Bench for tlc5955_receiver: one single-device and one two-device receiver
// share the serial pins and are compared against a bit-history model.
module tb_tlc5955_receiver;
  import tlc5955_pkg::*;

  localparam int W1  = 769;
  localparam int W2  = 1538;
  localparam int Lat = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic lat   = 1'b0;

  logic          miso1, v1, err1, miso2, v2, err2;
  logic [W1-1:0] d1;
  logic [0:0]    c1;
  logic [W2-1:0] d2;
  logic [1:0]    c2;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tlc5955_receiver #(.DaisyChain(1), .SyncStages(2)) dut1 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .lat(lat),
    .miso(miso1), .out_valid(v1), .out_data(d1), .out_ctrl(c1), .frame_err(err1)
  );

  tlc5955_receiver #(.DaisyChain(2), .SyncStages(2)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .lat(lat),
    .miso(miso2), .out_valid(v2), .out_data(d2), .out_ctrl(c2), .frame_err(err2)
  );

  // ---------------- checkers ----------------
  task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      first = -1;
      for (int i = W2 - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      errors++;
      $display("FAIL %s: first differing bit %0d, low word got %h expected %h",
               name, first, act[31:0], exp[31:0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins seen at cycle n act on the outputs Lat cycles later; bits are kept as
  // a newest-first history so device data is just the most recent bits.
  bit            hist_bits[$];
  int            cnt_m;
  logic          ph_s[0:7];
  logic          ph_m[0:7];
  logic          ph_l[0:7];
  logic          rst_q = 1'b1;
  logic [W1-1:0] md1;
  logic [0:0]    mc1;
  logic [W2-1:0] md2;
  logic [1:0]    mc2;
  logic          mv, me1, me2, mm1, mm2;

  always @(negedge clk) begin
    logic rs, rl, bb;
    if (rst_q) begin
      hist_bits.delete();
      cnt_m = 0;
      md1 = '0; md2 = '0; mc1 = '0; mc2 = '0;
      mv = 1'b0; me1 = 1'b0; me2 = 1'b0; mm1 = 1'b0; mm2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
        ph_s[k] = 1'b0; ph_m[k] = 1'b0; ph_l[k] = 1'b0;
      end
    end else begin
      mm1 = (hist_bits.size() >= W1) ? hist_bits[W1-1] : 1'b0;
      mm2 = (hist_bits.size() >= W2) ? hist_bits[W2-1] : 1'b0;
      rs  = ph_s[Lat-1] & ~ph_s[Lat];
      rl  = ph_l[Lat-1] & ~ph_l[Lat];
      mv  = rl;
      me1 = 1'b0;
      me2 = 1'b0;
      if (rs) begin
        hist_bits.push_front(ph_m[Lat-1]);
        if (hist_bits.size() > W2) void'(hist_bits.pop_back());
        cnt_m++;
      end
      if (rl) begin
        me1 = (cnt_m != W1);
        me2 = (cnt_m != W2);
        cnt_m = 0;
        for (int i = 0; i < W2; i++) begin
          bb = (i < hist_bits.size()) ? hist_bits[i] : 1'b0;
          if (i < W1) md1[i] = bb;
          md2[i] = bb;
        end
        mc1[0] = md1[CtrlBitIndex];
        mc2    = {md2[W1 + CtrlBitIndex], md2[CtrlBitIndex]};
      end
    end

    check_bits("dut1.out_valid", 32'(v1), 32'(mv));
    check_bits("dut1.frame_err", 32'(err1), 32'(me1));
    check_bits("dut1.miso", 32'(miso1), 32'(mm1));
    check_bits("dut1.out_ctrl", 32'(c1), 32'(mc1));
    check_vec("dut1.out_data", W2'(d1), W2'(md1));
    check_bits("dut2.out_valid", 32'(v2), 32'(mv));
    check_bits("dut2.frame_err", 32'(err2), 32'(me2));
    check_bits("dut2.miso", 32'(miso2), 32'(mm2));
    check_bits("dut2.out_ctrl", 32'(c2), 32'(mc2));
    check_vec("dut2.out_data", d2, md2);
    if (v1) vcnt++;

    for (int k = 7; k > 0; k--) begin
      ph_s[k] = ph_s[k-1]; ph_m[k] = ph_m[k-1]; ph_l[k] = ph_l[k-1];
    end
    ph_s[0] = sclk;
    ph_m[0] = mosi;
    ph_l[0] = lat;
    rst_q   = reset;
  end

  // ---------------- driver tasks ----------------
  logic [W2-1:0] cap_d2;
  logic [W1-1:0] cap_d1;
  logic [1:0]    cap_c2;
  logic          cap_c1, cap_e1, cap_e2;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    mosi = b;
    sclk = 1'b1;
    step(hi);
    sclk = 1'b0;
    step(lo);
  endtask

  // MSB first; period 0 selects randomized high/low times.
  task automatic send_frame(input logic [W2-1:0] f, input int n, input int period);
    for (int i = n - 1; i >= 0; i--) begin
      if (period > 0) send_bit(f[i], period / 2, period / 2);
      else send_bit(f[i], $urandom_range(1, 2), $urandom_range(1, 2));
    end
  endtask

  task automatic rand_frame(output logic [W2-1:0] f);
    for (int i = 0; i < W2; i++) f[i] = 1'($urandom_range(0, 1));
  endtask

  // Raises lat, waits a bounded time for the strobe and captures both DUTs.
  task automatic latch_capture(input int hi);
    bit seen;
    seen = 1'b0;
    lat  = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (v1) begin
        seen   = 1'b1;
        cap_d1 = d1; cap_c1 = c1[0]; cap_e1 = err1;
        cap_d2 = d2; cap_c2 = c2;    cap_e2 = err2;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL latch_timeout: got no out_valid within 12 cycles, expected one");
    end
    @(posedge clk);
    #1;
    step(hi);
    lat = 1'b0;
    step(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W2-1:0] f;
    int            n, v_before;

    step(5);
    reset = 1'b0;
    step(5);
    check_bits("reset.out_valid", 32'(v1), 32'd0);
    check_vec("reset.out_data", W2'(d1), '0);
    check_bits("reset.miso", 32'(miso1), 32'd0);

    // Slow GS frame carrying 0xA5.
    f = '0;
    f[7:0] = 8'hA5;
    send_frame(f, W1, 16);
    latch_capture(8);
    check_vec("gs.out_data", W2'(cap_d1), W2'(769'h0A5));
    check_bits("gs.out_ctrl", 32'(cap_c1), 32'd0);
    check_bits("gs.frame_err", 32'(cap_e1), 32'd0);
    check_bits("gs.dut2_frame_err", 32'(cap_e2), 32'd1);

    // Control frame.
    rand_frame(f);
    f[768] = 1'b1;
    f[767:760] = 8'h96;
    send_frame(f, W1, 0);
    latch_capture(6);
    check_bits("ctrl.out_ctrl", 32'(cap_c1), 32'd1);
    check_bits("ctrl.key", 32'(cap_d1[767:760]), 32'h96);
    check_bits("ctrl.frame_err", 32'(cap_e1), 32'd0);

    // Short frame then a good one.
    rand_frame(f);
    send_frame(f, 700, 0);
    latch_capture(5);
    check_bits("short.frame_err", 32'(cap_e1), 32'd1);
    rand_frame(f);
    send_frame(f, W1, 0);
    latch_capture(5);
    check_bits("after_short.frame_err", 32'(cap_e1), 32'd0);
    check_vec("after_short.out_data", W2'(cap_d1), W2'(f[W1-1:0]));

    // Last bit coincident with lat.
    rand_frame(f);
    send_frame(f, 768, 0);
    mosi = 1'b1;
    sclk = 1'b1;
    latch_capture(3);
    sclk = 1'b0;
    step(3);
    check_bits("simul.out_data0", 32'(cap_d1[0]), 32'd1);
    check_bits("simul.frame_err", 32'(cap_e1), 32'd0);
    rand_frame(f);
    send_frame(f, W1, 0);
    latch_capture(5);
    check_bits("after_simul.frame_err", 32'(cap_e1), 32'd0);

    // Reset in the middle of a frame.
    rand_frame(f);
    send_frame(f, 300, 0);
    v_before = vcnt;
    step(6);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(6);
    check_bits("midreset.no_valid", 32'(vcnt - v_before), 32'd0);
    check_vec("midreset.out_data", W2'(d1), '0);
    rand_frame(f);
    send_frame(f, W1, 0);
    latch_capture(5);
    check_vec("midreset.next_frame", W2'(cap_d1), W2'(f[W1-1:0]));
    check_bits("midreset.frame_err", 32'(cap_e1), 32'd0);

    // Two-device chain, three frames; the middle latch is held high.
    for (int k = 0; k < 3; k++) begin
      rand_frame(f);
      send_frame(f, W2, 0);
      v_before = vcnt;
      latch_capture((k == 1) ? 60 : 5);
      check_bits("chain.valid_count", 32'(vcnt - v_before), 32'd1);
      check_vec("chain.out_data", cap_d2, f);
      check_bits("chain.out_ctrl", 32'(cap_c2), 32'({f[W1 + CtrlBitIndex], f[CtrlBitIndex]}));
      check_bits("chain.frame_err", 32'(cap_e2), 32'd0);
    end

    // Random-length frames, checked by the model alone.
    for (int k = 0; k < 2; k++) begin
      rand_frame(f);
      n = $urandom_range(700, 1600);
      send_frame(f, n, 0);
      latch_capture($urandom_range(1, 20));
    end

    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached before the end of stimulus");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
